// File: rtl/sw_input_conditioner.sv
// Slide-switch front end for the picoMIPS core: per-bit sync + debounce,
// handshake-switch edge pulses, and a captured data word with valid/ack/overrun.

module sw_db_lane #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // any cycle agreeing with the clean level restarts the count
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module sw_input_conditioner #(
    parameter int WIDTH     = 10,
    parameter int DATA_W    = 8,
    parameter int HS_BIT    = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  sw_raw,
    output logic [WIDTH-1:0]  sw_clean,
    output logic              hs_rise,
    output logic              hs_fall,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              overrun
);
    // a DB_CYCLES of 1 still needs a one-bit counter
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, VALID, WAIT_REL} state_t;

    state_t              state, state_d;
    logic                hs_prev;
    logic [DATA_W-1:0]   dout_d;
    logic                dv_d, ovr_d;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_lane
        sw_db_lane #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .clean (sw_clean[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev <= 1'b0;
            hs_rise <= 1'b0;
            hs_fall <= 1'b0;
        end else begin
            hs_prev <= sw_clean[HS_BIT];
            hs_rise <= sw_clean[HS_BIT] & ~hs_prev;
            hs_fall <= ~sw_clean[HS_BIT] & hs_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            data_out   <= dout_d;
            data_valid <= dv_d;
            overrun    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state;
        dout_d  = data_out;
        dv_d    = data_valid;
        ovr_d   = overrun;
        case (state)
            IDLE: begin
                if (hs_rise) begin
                    dout_d  = sw_clean[DATA_W-1:0];
                    dv_d    = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (data_ack) begin
                    dv_d    = 1'b0;
                    state_d = WAIT_REL;
                end
                // a new edge while the word is still pending is dropped
                if (hs_rise) ovr_d = 1'b1;
            end
            WAIT_REL: begin
                if (!sw_clean[HS_BIT]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed cycle-by-cycle vectors for sw_input_conditioner plus a few
// hand-written handshake corner sequences.

module tb_sw_input_conditioner;
    logic       clk;
    logic       reset;
    logic [9:0] sw_raw;
    logic [9:0] sw_clean;
    logic       hs_rise, hs_fall;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    sw_input_conditioner #(.WIDTH(10), .DATA_W(8), .HS_BIT(8), .DB_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .hs_rise    (hs_rise),
        .hs_fall    (hs_fall),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] sw;
        logic       ack;
        logic [9:0] clean;
        logic       rise;
        logic       fall;
        logic [7:0] dout;
        logic       dv;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic rst, input logic [9:0] sw, input logic ack,
                       input logic [9:0] clean, input logic rise, input logic fall,
                       input logic [7:0] dout, input logic dv, input logic ovr);
        vec_t v;
        v.rst = rst; v.sw = sw; v.ack = ack; v.clean = clean; v.rise = rise;
        v.fall = fall; v.dout = dout; v.dv = dv; v.ovr = ovr;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; sw_raw = '0; data_ack = 1'b0;

        // rst, sw, ack | clean, rise, fall, dout, dv, ovr  (state after that edge)
        add(2,  1, 10'h000, 0, 10'h000, 0, 0, 8'h00, 0, 0);
        add(10, 0, 10'h000, 0, 10'h000, 0, 0, 8'h00, 0, 0);
        // stable change lands on the 6th edge, SW8 low so no capture
        add(5,  0, 10'h0A5, 0, 10'h000, 0, 0, 8'h00, 0, 0);
        add(3,  0, 10'h0A5, 0, 10'h0A5, 0, 0, 8'h00, 0, 0);
        // two 3-cycle glitches on SW3 separated by a short gap
        add(3,  0, 10'h0AD, 0, 10'h0A5, 0, 0, 8'h00, 0, 0);
        add(2,  0, 10'h0A5, 0, 10'h0A5, 0, 0, 8'h00, 0, 0);
        add(3,  0, 10'h0AD, 0, 10'h0A5, 0, 0, 8'h00, 0, 0);
        add(6,  0, 10'h0A5, 0, 10'h0A5, 0, 0, 8'h00, 0, 0);
        // capture 0x3C
        add(5,  0, 10'h13C, 0, 10'h0A5, 0, 0, 8'h00, 0, 0);
        add(1,  0, 10'h13C, 0, 10'h13C, 0, 0, 8'h00, 0, 0);
        add(1,  0, 10'h13C, 0, 10'h13C, 1, 0, 8'h00, 0, 0);
        add(1,  0, 10'h13C, 0, 10'h13C, 0, 0, 8'h3C, 1, 0);
        add(5,  0, 10'h155, 0, 10'h13C, 0, 0, 8'h3C, 1, 0);
        add(1,  0, 10'h155, 0, 10'h155, 0, 0, 8'h3C, 1, 0);
        add(1,  0, 10'h155, 1, 10'h155, 0, 0, 8'h3C, 0, 0);
        add(5,  0, 10'h055, 0, 10'h155, 0, 0, 8'h3C, 0, 0);
        add(1,  0, 10'h055, 0, 10'h055, 0, 0, 8'h3C, 0, 0);
        add(1,  0, 10'h055, 0, 10'h055, 0, 1, 8'h3C, 0, 0);
        add(1,  0, 10'h055, 1, 10'h055, 0, 0, 8'h3C, 0, 0);
        add(1,  0, 10'h055, 0, 10'h055, 0, 0, 8'h3C, 0, 0);
        // overrun: capture 0x11, drop 0x22
        add(5,  0, 10'h111, 0, 10'h055, 0, 0, 8'h3C, 0, 0);
        add(1,  0, 10'h111, 0, 10'h111, 0, 0, 8'h3C, 0, 0);
        add(1,  0, 10'h111, 0, 10'h111, 1, 0, 8'h3C, 0, 0);
        add(1,  0, 10'h111, 0, 10'h111, 0, 0, 8'h11, 1, 0);
        add(5,  0, 10'h022, 0, 10'h111, 0, 0, 8'h11, 1, 0);
        add(1,  0, 10'h022, 0, 10'h022, 0, 0, 8'h11, 1, 0);
        add(1,  0, 10'h022, 0, 10'h022, 0, 1, 8'h11, 1, 0);
        add(5,  0, 10'h122, 0, 10'h022, 0, 0, 8'h11, 1, 0);
        add(1,  0, 10'h122, 0, 10'h122, 0, 0, 8'h11, 1, 0);
        add(1,  0, 10'h122, 0, 10'h122, 1, 0, 8'h11, 1, 0);
        add(1,  0, 10'h122, 0, 10'h122, 0, 0, 8'h11, 1, 1);
        add(1,  0, 10'h122, 1, 10'h122, 0, 0, 8'h11, 0, 1);
        add(3,  0, 10'h122, 0, 10'h122, 0, 0, 8'h11, 0, 1);
        // release, recapture 0x3C, then reset mid-VALID with SW8 still high
        add(5,  0, 10'h03C, 0, 10'h122, 0, 0, 8'h11, 0, 1);
        add(1,  0, 10'h03C, 0, 10'h03C, 0, 0, 8'h11, 0, 1);
        add(1,  0, 10'h03C, 0, 10'h03C, 0, 1, 8'h11, 0, 1);
        add(1,  0, 10'h03C, 0, 10'h03C, 0, 0, 8'h11, 0, 1);
        add(5,  0, 10'h13C, 0, 10'h03C, 0, 0, 8'h11, 0, 1);
        add(1,  0, 10'h13C, 0, 10'h13C, 0, 0, 8'h11, 0, 1);
        add(1,  0, 10'h13C, 0, 10'h13C, 1, 0, 8'h11, 0, 1);
        add(1,  0, 10'h13C, 0, 10'h13C, 0, 0, 8'h3C, 1, 1);
        add(1,  1, 10'h13C, 0, 10'h000, 0, 0, 8'h00, 0, 0);
        add(5,  0, 10'h13C, 0, 10'h000, 0, 0, 8'h00, 0, 0);
        add(1,  0, 10'h13C, 0, 10'h13C, 0, 0, 8'h00, 0, 0);
        add(1,  0, 10'h13C, 0, 10'h13C, 1, 0, 8'h00, 0, 0);
        add(1,  0, 10'h13C, 0, 10'h13C, 0, 0, 8'h3C, 1, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            reset = tbl[k].rst; sw_raw = tbl[k].sw; data_ack = tbl[k].ack;
            tick();
            check($sformatf("vec[%0d] {clean,rise,fall,dout,dv,ovr}", k),
                  {9'd0, sw_clean, hs_rise, hs_fall, data_out, data_valid, overrun},
                  {9'd0, tbl[k].clean, tbl[k].rise, tbl[k].fall, tbl[k].dout, tbl[k].dv, tbl[k].ovr});
        end

        // VALID holding 0x3C: release SW8 and time the debounce
        @(negedge clk); sw_raw = 10'h03C;
        n = 0;
        do begin tick(); n++; end while (sw_clean[8] !== 1'b0 && n < 12);
        check("release_latency", n, 6);

        // re-press with data 0x3D; ack lands in the same cycle as hs_rise
        @(negedge clk); sw_raw = 10'h13D;
        n = 0;
        do begin tick(); n++; end while (hs_rise !== 1'b1 && n < 12);
        check("rise_latency", n, 7);
        @(negedge clk); data_ack = 1'b1;
        tick();
        check("ack_rise_same_cycle dv", data_valid, 0);
        check("ack_rise_same_cycle ovr", overrun, 1);
        check("ack_rise_same_cycle dout", data_out, 8'h3C);
        @(negedge clk); data_ack = 1'b0;
        repeat (3) tick();
        check("wait_rel holds dv", data_valid, 0);
        check("wait_rel holds dout", data_out, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_input_conditioner.md
Name: sw_input_conditioner

Overview:
Upstream stage of the picoMIPS core. It conditions the raw DE0 slide switches before the core samples them. The block synchronises and debounces every switch bit, then generates one-cycle edge pulses on the handshake switch. On each handshake rising edge it captures the data switches into a held register and runs a valid/ack handshake toward the processor. It runs on the same slow clock as the core.

Parameters:
WIDTH, 10, number of switch bits conditioned (SW9..SW0)
DATA_W, 8, number of low switch bits captured as the data word (SW7..SW0)
HS_BIT, 8, index of the handshake switch
DB_CYCLES, 4, consecutive mismatched cycles required before a debounced bit changes (>=1)

Ports:
clk  input  1  slow system clock, shared with the picoMIPS core
reset  input  1  synchronous, active-high reset
sw_raw  input  WIDTH  asynchronous switch levels
sw_clean  output  WIDTH  synchronised, debounced switch levels
hs_rise  output  1  one-cycle pulse on a debounced 0->1 of sw_clean[HS_BIT]
hs_fall  output  1  one-cycle pulse on a debounced 1->0 of sw_clean[HS_BIT]
data_out  output  DATA_W  captured data word
data_valid  output  1  data_out holds an unacknowledged word
data_ack  input  1  processor has consumed data_out
overrun  output  1  sticky: a handshake edge was dropped while data_valid was high

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: sync stages 0, sw_clean 0, debounce counters 0, hs_rise 0, hs_fall 0, data_out 0, data_valid 0, overrun 0, FSM in IDLE. This holds even if reset asserts mid-handshake.
- Synchroniser: two flops per bit, sw_raw -> s1 -> s2.
- Debounce (independent per bit, counter width clog2(DB_CYCLES)):
  - If s2[i] == sw_clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1: sw_clean[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
- Debounce timing:
  - A raw change held stable appears on sw_clean at the (DB_CYCLES+2)th rising edge after it occurs.
  - A glitch lasting fewer than DB_CYCLES cycles at s2 never reaches sw_clean.
- Edge detect:
  - hs_prev is a register of sw_clean[HS_BIT].
  - hs_rise = sw_clean[HS_BIT] & ~hs_prev, registered so it is high for exactly one cycle.
  - hs_fall is the symmetric falling-edge pulse.
- Handshake FSM, states IDLE, VALID, WAIT_REL:
  - IDLE: on hs_rise, data_out <= sw_clean[DATA_W-1:0], data_valid <= 1, go to VALID.
  - VALID: data_out and data_valid are held. On data_ack, data_valid <= 0 and go to WAIT_REL.
  - VALID, hs_rise without data_ack: set overrun <= 1, keep the old data_out, stay in VALID.
  - VALID, hs_rise and data_ack in the same cycle: honour the ack, go to WAIT_REL, and set overrun (the new word is dropped).
  - WAIT_REL: when sw_clean[HS_BIT] == 0, go to IDLE. If it is already 0, WAIT_REL lasts exactly one cycle.
  - data_ack in IDLE or WAIT_REL is ignored.
- overrun clears only on reset.
- After reset with the handshake switch physically high: sw_clean rises DB_CYCLES+2 cycles later, generating hs_rise and a normal capture.
- Latency: data_valid rises on the edge after hs_rise; data_valid falls on the edge after data_ack is sampled in VALID.
- No combinational path from any input to any output.

Test Plan:
- Reset then sw_raw=10'h000 for 10 cycles -> all outputs 0, FSM IDLE.
- sw_raw 10'h000 -> 10'h0A5 held -> sw_clean==10'h0A5 exactly 6 edges after the change; hs_rise never pulses.
- Glitch: sw_raw[3] high for 3 cycles, then low -> sw_clean[3] stays 0, all counters return to 0.
- Capture:
  - sw_raw=10'h13C (SW8=1, data 0x3C) held -> hs_rise pulses one cycle, then data_out==8'h3C and data_valid==1.
  - Change data switches to 0x55 -> data_out stays 0x3C.
  - Pulse data_ack one cycle -> data_valid==0 next edge.
  - Release SW8 -> hs_fall pulses, FSM returns to IDLE.
- Overrun: capture 0x11, do not ack. Toggle SW8 low then high with data 0x22 -> overrun==1, data_out==8'h11. Then ack -> data_valid==0, overrun stays 1 until reset.
- Reset asserted while in VALID with data_out==0x3C -> next edge all outputs 0. SW8 still high -> new capture of the current switches DB_CYCLES+2 cycles after reset deasserts.
